// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: unsigned 8x8 -> 16-bit multiplier built around one combinational 4x4 array
// multiplier. The controller feeds it one nibble pair per cycle and shift-accumulates the four
// partial products. Operands arrive and the result leaves over valid/ready handshakes.
//
// Ports (mult8_seq_ctrl):
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand pair on a_i/b_i is valid
//   in_ready_o   controller can accept operands (IDLE only)
//   a_i, b_i     8-bit unsigned operands, sampled at acceptance only
//   out_valid_o  product_o is valid (DONE only)
//   out_ready_i  consumer accepts product_o
//   product_o    16-bit registered product
//   busy_o       high in any state except IDLE
//
// Ports (array_mult_structural):
//   m_i, q_i     4-bit unsigned operands
//   p_o          8-bit unsigned product

module array_mult_structural (
    input  logic [3:0] m_i,
    input  logic [3:0] q_i,
    output logic [7:0] p_o
);
    logic [3:0] pp0, pp1, pp2, pp3;
    logic [4:0] s1, s2, s3;

    assign pp0 = m_i & {4{q_i[0]}};
    assign pp1 = m_i & {4{q_i[1]}};
    assign pp2 = m_i & {4{q_i[2]}};
    assign pp3 = m_i & {4{q_i[3]}};

    // Each row adds the next partial product to the previous row's sum shifted right by one;
    // the dropped LSB of every row is a finished product bit.
    assign s1 = {2'b00, pp0[3:1]} + {1'b0, pp1};
    assign s2 = {1'b0, s1[4:1]} + {1'b0, pp2};
    assign s3 = {1'b0, s2[4:1]} + {1'b0, pp3};

    assign p_o = {s3, s2[0], s1[0], pp0[0]};
endmodule

module mult8_seq_ctrl #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] product_o,
    output logic        busy_o
);
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMul0 = 3'd1,
        StMul1 = 3'd2,
        StMul2 = 3'd3,
        StMul3 = 3'd4,
        StDone = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;

    logic [3:0]  mult_m, mult_q;
    logic [7:0]  mult_p;
    logic [15:0] mult_p_ext;

    array_mult_structural u_mult (
        .m_i (mult_m),
        .q_i (mult_q),
        .p_o (mult_p)
    );

    assign mult_p_ext = {8'h00, mult_p};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mult_m  = 4'h0;
        mult_q  = 4'h0;

        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    acc_d = 16'h0000;
                    if (EARLY_EXIT && ((a_i == 8'h00) || (b_i == 8'h00))) begin
                        state_d = StDone;
                    end else begin
                        state_d = StMul0;
                    end
                end
            end
            StMul0: begin
                mult_m  = a_q[3:0];
                mult_q  = b_q[3:0];
                acc_d   = acc_q + mult_p_ext;
                state_d = StMul1;
            end
            StMul1: begin
                mult_m  = a_q[7:4];
                mult_q  = b_q[3:0];
                acc_d   = acc_q + (mult_p_ext << 4);
                state_d = StMul2;
            end
            StMul2: begin
                mult_m  = a_q[3:0];
                mult_q  = b_q[7:4];
                acc_d   = acc_q + (mult_p_ext << 4);
                state_d = StMul3;
            end
            StMul3: begin
                mult_m  = a_q[7:4];
                mult_q  = b_q[7:4];
                acc_d   = acc_q + (mult_p_ext << 8);
                state_d = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                // Unused encodings recover to IDLE.
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign product_o   = acc_q;
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl. Two instances: u_dut (EARLY_EXIT=0) carries the
// directed and random tests, u_dut_ee (EARLY_EXIT=1) covers the zero-operand bypass.
// Inputs change and outputs are sampled just after the falling clock edge.

module tb_mult8_seq_ctrl;
    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] product;

    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_busy;
    logic [7:0]  e_a, e_b;
    logic [15:0] e_product;

    int total = 0;
    int bad   = 0;

    mult8_seq_ctrl #(.EARLY_EXIT(1'b0)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .product_o   (product),
        .busy_o      (busy)
    );

    mult8_seq_ctrl #(.EARLY_EXIT(1'b1)) u_dut_ee (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (e_in_valid),
        .in_ready_o  (e_in_ready),
        .a_i         (e_a),
        .b_i         (e_b),
        .out_valid_o (e_out_valid),
        .out_ready_i (e_out_ready),
        .product_o   (e_product),
        .busy_o      (e_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on the selected instance with out_ready held high. Starts and ends just
    // after a falling edge; checks acceptance, latency, product and the return to IDLE.
    task automatic run_txn(input bit sel, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic [15:0] exp_p, input int exp_lat, input string tag);
        int lat;
        if (sel) begin e_in_valid = 1'b1; e_a = ta; e_b = tb_v; e_out_ready = 1'b1; end
        else     begin in_valid = 1'b1; a = ta; b = tb_v; out_ready = 1'b1; end
        chk({tag, "_in_ready"}, 32'(sel ? e_in_ready : in_ready), 32'd1);
        @(negedge clk);
        if (sel) begin e_in_valid = 1'b0; e_a = 8'hC3; e_b = 8'h5A; end
        else     begin in_valid = 1'b0; a = 8'hC3; b = 8'h5A; end
        lat = 1;
        while (!(sel ? e_out_valid : out_valid) && lat < 20) begin
            chk({tag, "_busy"}, 32'(sel ? e_busy : busy), 32'd1);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_product"}, 32'(sel ? e_product : product), 32'(exp_p));
        @(negedge clk);
        chk({tag, "_idle_ready"}, 32'(sel ? e_in_ready : in_ready), 32'd1);
        chk({tag, "_idle_ovalid"}, 32'(sel ? e_out_valid : out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] hold;
        int last_out, accepted, emitted, cyc, acc_cyc, n_out;
        bit prev_ov;

        rst = 1'b1;
        in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b0;
        e_in_valid = 1'b0; e_a = 8'h00; e_b = 8'h00; e_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_product", 32'(product), 32'h0);

        run_txn(1'b0, 8'h12, 8'h34, 16'h03A8, 5, "t12x34");
        run_txn(1'b0, 8'hFF, 8'hFF, 16'hFE01, 5, "tFFxFF");
        run_txn(1'b0, 8'hA5, 8'h3C, 16'h26AC, 5, "tA5x3C");

        // Streaming: in_valid and out_ready held high, results must be exactly 6 cycles apart.
        in_valid = 1'b1; a = 8'h21; b = 8'h43; out_ready = 1'b1;
        last_out = -1; n_out = 0; cyc = 0;
        while (n_out < 4 && cyc < 100) begin
            if (out_valid) begin
                chk("stream_product", 32'(product), 32'(16'h21 * 16'h43));
                if (last_out >= 0) chk("stream_period", 32'(cyc - last_out), 32'd6);
                last_out = cyc;
                n_out++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("stream_count", 32'(n_out), 32'd4);
        in_valid = 1'b0;
        while (!in_ready && cyc < 200) begin @(negedge clk); cyc++; end

        // Backpressure with input noise while DONE is held.
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'h0F; b = 8'hF0;
        @(negedge clk);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            in_valid = 1'(($urandom));
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency", 32'(cyc + 1), 32'd5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_product", 32'(product), 32'h0E10);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            in_valid = 1'($urandom);
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_ovalid", 32'(out_valid), 32'd0);

        // Reset while the transaction is in MUL2.
        in_valid = 1'b1; a = 8'h55; b = 8'h66;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_product", 32'(product), 32'h0);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        hold = 16'h0;
        for (int i = 0; i < 8; i++) begin
            hold = hold | 16'(out_valid);
            @(negedge clk);
        end
        chk("rst_mid_no_result", 32'(hold), 32'h0);

        // Zero operand with and without the bypass.
        run_txn(1'b1, 8'h00, 8'h7B, 16'h0000, 1, "ee_on_a0");
        run_txn(1'b1, 8'h7B, 8'h00, 16'h0000, 1, "ee_on_b0");
        run_txn(1'b1, 8'h12, 8'h34, 16'h03A8, 5, "ee_on_nz");
        run_txn(1'b0, 8'h00, 8'h7B, 16'h0000, 5, "ee_off_a0");

        // Random regression against an in-order queue of a*b.
        accepted = 0; emitted = 0; cyc = 0; acc_cyc = 0; prev_ov = 1'b0;
        while (emitted < 1000 && cyc < 40000) begin
            in_valid  = (accepted < 1000) && ($urandom_range(0, 2) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && !prev_ov) chk("rand_latency", 32'(cyc - acc_cyc), 32'd5);
            if (out_valid && out_ready) begin
                chk("rand_have_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("rand_product", 32'(product), 32'(exp_q.pop_front()));
                emitted++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(16'(a) * 16'(b));
                accepted++;
                acc_cyc = cyc;
            end
            prev_ov = out_valid;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_emitted", 32'(emitted), 32'd1000);
        chk("rand_accepted", 32'(accepted), 32'd1000);
        chk("rand_leftover", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
